// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute-stage datapath: width and ALU op encodings.
package alu_exec_pkg;

    localparam int unsigned W = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_MULT  = 4'd11;
    localparam logic [3:0] ALU_MULTU = 4'd12;
    localparam logic [3:0] ALU_LUI   = 4'd13;
    localparam logic [3:0] ALU_ADDU  = 4'd14;
    localparam logic [3:0] ALU_SUBU  = 4'd15;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: operands to result, product halves, overflow and zero.
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [3:0]   alu_control,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    output logic [W-1:0] result,
    output logic [W-1:0] hi_next,
    output logic [W-1:0] lo_next,
    output logic         mul_op,
    output logic         overflow,
    output logic         zero
);

    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] prod_u;
    logic [4:0]     sh;

    assign sum    = src_a + src_b;
    assign diff   = src_a - src_b;
    assign sh     = src_a[4:0];
    assign prod_s = $signed({{W{src_a[W-1]}}, src_a}) * $signed({{W{src_b[W-1]}}, src_b});
    assign prod_u = {{W{1'b0}}, src_a} * {{W{1'b0}}, src_b};

    // Operation decode; only ADD/SUB report overflow, only MULT/MULTU produce hi/lo.
    always_comb begin
        result   = '0;
        hi_next  = '0;
        lo_next  = '0;
        mul_op   = 1'b0;
        overflow = 1'b0;
        unique case (alu_control)
            ALU_ADD: begin
                result   = sum;
                overflow = (src_a[W-1] == src_b[W-1]) && (sum[W-1] != src_a[W-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (src_a[W-1] != src_b[W-1]) && (diff[W-1] != src_a[W-1]);
            end
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_NOR:  result = ~(src_a | src_b);
            ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: result = {{(W-1){1'b0}}, (src_a < src_b)};
            ALU_SLL:  result = src_b << sh;
            ALU_SRL:  result = src_b >> sh;
            ALU_SRA:  result = $unsigned($signed(src_b) >>> sh);
            ALU_MULT: begin
                result  = prod_s[W-1:0];
                hi_next = prod_s[2*W-1:W];
                lo_next = prod_s[W-1:0];
                mul_op  = 1'b1;
            end
            ALU_MULTU: begin
                result  = prod_u[W-1:0];
                hi_next = prod_u[2*W-1:W];
                lo_next = prod_u[W-1:0];
                mul_op  = 1'b1;
            end
            ALU_LUI:  result = src_b << 16;
            ALU_ADDU: result = sum;
            ALU_SUBU: result = diff;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: srcA select, registered ALU outputs and branch-target register.
module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_en,
    input  logic [3:0]  alu_control,
    input  logic [31:0] read_data1,
    input  logic [4:0]  shamt,
    input  logic        select_shamt,
    input  logic [31:0] alu_srcB,
    input  logic        branch_en,
    input  logic        branch_ne,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] alu_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        overflow,
    output logic        alu_zero,
    output logic [31:0] pc_out
);

    logic [W-1:0] src_a;
    logic [W-1:0] result_d;
    logic [W-1:0] hi_d;
    logic [W-1:0] lo_d;
    logic         mul_op;
    logic         overflow_d;
    logic         zero_d;
    logic         taken;

    assign src_a = select_shamt ? {27'b0, shamt} : read_data1;

    alu_core u_alu_core (
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (alu_srcB),
        .result      (result_d),
        .hi_next     (hi_d),
        .lo_next     (lo_d),
        .mul_op      (mul_op),
        .overflow    (overflow_d),
        .zero        (zero_d)
    );

    // Branch decision reads the registered flag, i.e. the previous EXECUTE result.
    assign taken = alu_zero ^ branch_ne;

    // Output registers; reset wins over both enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result <= '0;
            hi         <= '0;
            lo         <= '0;
            overflow   <= 1'b0;
            alu_zero   <= 1'b0;
            pc_out     <= '0;
        end else begin
            if (alu_en) begin
                alu_result <= result_d;
                overflow   <= overflow_d;
                alu_zero   <= zero_d;
                if (mul_op) begin
                    hi <= hi_d;
                    lo <= lo_d;
                end
            end
            if (branch_en) begin
                pc_out <= taken ? (pc + imm) : pc;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors with hand-computed results.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_en;
    logic [3:0]  alu_control;
    logic [31:0] read_data1;
    logic [4:0]  shamt;
    logic        select_shamt;
    logic [31:0] alu_srcB;
    logic        branch_en;
    logic        branch_ne;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        overflow;
    logic        alu_zero;
    logic [31:0] pc_out;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ov;
        logic        z;
        logic [31:0] pco;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .alu_en       (alu_en),
        .alu_control  (alu_control),
        .read_data1   (read_data1),
        .shamt        (shamt),
        .select_shamt (select_shamt),
        .alu_srcB     (alu_srcB),
        .branch_en    (branch_en),
        .branch_ne    (branch_ne),
        .imm          (imm),
        .pc           (pc),
        .alu_result   (alu_result),
        .hi           (hi),
        .lo           (lo),
        .overflow     (overflow),
        .alu_zero     (alu_zero),
        .pc_out       (pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are valid one cycle after issue; sample on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "alu_result", alu_result, e.res);
            chk(e.name, "hi", hi, e.hi);
            chk(e.name, "lo", lo, e.lo);
            chk(e.name, "overflow", {31'b0, overflow}, {31'b0, e.ov});
            chk(e.name, "alu_zero", {31'b0, alu_zero}, {31'b0, e.z});
            chk(e.name, "pc_out", pc_out, e.pco);
        end
    end

    task automatic step(input string nm, input logic rst, input logic aen, input logic [3:0] op,
                        input logic [31:0] rd1, input logic ssel, input logic [4:0] sh,
                        input logic [31:0] b, input logic ben, input logic bne,
                        input logic [31:0] im, input logic [31:0] p,
                        input logic [31:0] e_res, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic e_ov, input logic e_z,
                        input logic [31:0] e_pc);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        alu_en       = aen;
        alu_control  = op;
        read_data1   = rd1;
        select_shamt = ssel;
        shamt        = sh;
        alu_srcB     = b;
        branch_en    = ben;
        branch_ne    = bne;
        imm          = im;
        pc           = p;
        @(posedge clk);
        e.name = nm;
        e.res  = e_res;
        e.hi   = e_hi;
        e.lo   = e_lo;
        e.ov   = e_ov;
        e.z    = e_z;
        e.pco  = e_pc;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; alu_en = 1'b0; alu_control = 4'd0; read_data1 = '0; shamt = '0;
        select_shamt = 1'b0; alu_srcB = '0; branch_en = 1'b0; branch_ne = 1'b0;
        imm = '0; pc = '0;
        //    name      rst aen op     rd1           ss sh     b             ben bne imm           pc
        //              res           hi            lo            ov z  pc_out
        step("reset",   1, 0, 4'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0,
                        32'h0,        32'h0,        32'h0,        0, 0, 32'h0);
        step("add_ovf", 0, 1, 4'd0,  32'h7FFFFFFF, 0, 5'd0,  32'h1,        0, 0, 32'h0,        32'h0,
                        32'h80000000, 32'h0,        32'h0,        1, 0, 32'h0);
        step("addu",    0, 1, 4'd14, 32'h7FFFFFFF, 0, 5'd0,  32'h1,        0, 0, 32'h0,        32'h0,
                        32'h80000000, 32'h0,        32'h0,        0, 0, 32'h0);
        step("sub_zero",0, 1, 4'd1,  32'h5,        0, 5'd0,  32'h5,        0, 0, 32'h0,        32'h0,
                        32'h0,        32'h0,        32'h0,        0, 1, 32'h0);
        step("beq_tk",  0, 0, 4'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'hFFFFFFFC, 32'h10,
                        32'h0,        32'h0,        32'h0,        0, 1, 32'h0C);
        step("bne_nt",  0, 0, 4'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1, 32'hFFFFFFFC, 32'h10,
                        32'h0,        32'h0,        32'h0,        0, 1, 32'h10);
        step("sra_sh",  0, 1, 4'd10, 32'hDEADBEEF, 1, 5'd4,  32'h80000000, 0, 0, 32'h0,        32'h0,
                        32'hF8000000, 32'h0,        32'h0,        0, 0, 32'h10);
        step("srl_sh",  0, 1, 4'd9,  32'hDEADBEEF, 1, 5'd4,  32'h80000000, 0, 0, 32'h0,        32'h0,
                        32'h08000000, 32'h0,        32'h0,        0, 0, 32'h10);
        step("mult",    0, 1, 4'd11, 32'hFFFFFFFE, 0, 5'd0,  32'h3,        0, 0, 32'h0,        32'h0,
                        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 32'h10);
        step("add_hold",0, 1, 4'd0,  32'h1,        0, 5'd0,  32'h2,        0, 0, 32'h0,        32'h0,
                        32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 32'h10);
        step("slt",     0, 1, 4'd6,  32'hFFFFFFFF, 0, 5'd0,  32'h1,        0, 0, 32'h0,        32'h0,
                        32'h1,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 32'h10);
        step("sltu",    0, 1, 4'd7,  32'hFFFFFFFF, 0, 5'd0,  32'h1,        0, 0, 32'h0,        32'h0,
                        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1, 32'h10);
        step("lui",     0, 1, 4'd13, 32'h0,        0, 5'd0,  32'h1234,     0, 0, 32'h0,        32'h0,
                        32'h12340000, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 32'h10);
        // Same-cycle EXECUTE and BRANCH: decision uses the old zero flag (0), so not taken.
        step("both_en", 0, 1, 4'd1,  32'h7,        0, 5'd0,  32'h7,        1, 0, 32'h8,        32'h100,
                        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1, 32'h100);
        step("br_wrap", 0, 0, 4'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h8,        32'hFFFFFFFC,
                        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1, 32'h4);
        step("multu",   0, 1, 4'd12, 32'hFFFFFFFF, 0, 5'd0,  32'h2,        0, 0, 32'h0,        32'h0,
                        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("sub_ovf", 0, 1, 4'd1,  32'h80000000, 0, 5'd0,  32'h1,        0, 0, 32'h0,        32'h0,
                        32'h7FFFFFFF, 32'h1,        32'hFFFFFFFE, 1, 0, 32'h4);
        step("nor",     0, 1, 4'd5,  32'h0,        0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0,
                        32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("xor",     0, 1, 4'd4,  32'hA5A5A5A5, 0, 5'd0,  32'hFFFF0000, 0, 0, 32'h0,        32'h0,
                        32'h5A5AA5A5, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("and",     0, 1, 4'd2,  32'hF0F0F0F0, 0, 5'd0,  32'hFF00FF00, 0, 0, 32'h0,        32'h0,
                        32'hF000F000, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("or",      0, 1, 4'd3,  32'h0F000000, 0, 5'd0,  32'h000000F0, 0, 0, 32'h0,        32'h0,
                        32'h0F0000F0, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("sll0",    0, 1, 4'd8,  32'hFFFFFFFF, 1, 5'd0,  32'h12345678, 0, 0, 32'h0,        32'h0,
                        32'h12345678, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("sll31",   0, 1, 4'd8,  32'h0,        1, 5'd31, 32'h1,        0, 0, 32'h0,        32'h0,
                        32'h80000000, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("subu",    0, 1, 4'd15, 32'h0,        0, 5'd0,  32'h1,        0, 0, 32'h0,        32'h0,
                        32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        // Shift amount 32 from read_data1: only A[4:0] is used, so B passes unchanged.
        step("sra32",   0, 1, 4'd10, 32'h20,       0, 5'd0,  32'h80000000, 0, 0, 32'h0,        32'h0,
                        32'h80000000, 32'h1,        32'hFFFFFFFE, 0, 0, 32'h4);
        step("rst_mid", 1, 1, 4'd0,  32'h1,        0, 5'd0,  32'h1,        1, 1, 32'h8,        32'h40,
                        32'h0,        32'h0,        32'h0,        0, 0, 32'h0);
        step("add_post",0, 1, 4'd0,  32'h1,        0, 5'd0,  32'h1,        0, 0, 32'h0,        32'h0,
                        32'h2,        32'h0,        32'h0,        0, 0, 32'h0);
        step("hold1",   0, 0, 4'd1,  32'h9,        0, 5'd0,  32'h3,        0, 0, 32'h4,        32'h80,
                        32'h2,        32'h0,        32'h0,        0, 0, 32'h0);
        step("hold2",   0, 0, 4'd11, 32'hFFFFFFFF, 0, 5'd0,  32'h7,        0, 1, 32'h4,        32'h90,
                        32'h2,        32'h0,        32'h0,        0, 0, 32'h0);
        step("hold3",   0, 0, 4'd13, 32'h0,        1, 5'd3,  32'hFFFF,     0, 0, 32'h4,        32'hA0,
                        32'h2,        32'h0,        32'h0,        0, 0, 32'h0);
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
